reg_file_sb: RTL and testbench

- Parametrised successor to the 16x16 three-address register file used by the MIPS datapath: two read ports (A, B), one write port (C).
- Adds write-to-read bypass, optional hardwired zero register, optional registered reads, and a per-register pending scoreboard.
- Decode reserves a destination, writeback clears it, and the Abusy/Bbusy flags drive hazard stall logic.

---
 rtl/reg_file_sb_if.sv | 29 ++
 rtl/reg_file_sb.sv | 78 +++++++
 tb/tb_reg_file_sb.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Read/write/reserve bus of the scoreboarded register file.
// master drives addresses, data and strobes; slave returns data and busy flags.
interface reg_file_sb_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic [AW-1:0]    Aaddr;
    logic [AW-1:0]    Baddr;
    logic [AW-1:0]    Caddr;
    logic [AW-1:0]    Rsvaddr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             Load;
    logic             Rsv;
    logic             Flush;
    logic             Abusy;
    logic             Bbusy;

    modport master (
        output Aaddr, Baddr, Caddr, Rsvaddr, C, Load, Rsv, Flush,
        input  A, B, Abusy, Bbusy
    );

    modport slave (
        input  Aaddr, Baddr, Caddr, Rsvaddr, C, Load, Rsv, Flush,
        output A, B, Abusy, Bbusy
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write bypass, optional zero
// register, optional registered reads and a per-register pending scoreboard.
module reg_file_sb #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit READ_REG = 1'b0
) (
    input  logic          clk,
    input  logic          Clear_n,
    reg_file_sb_if.slave  bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_n;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic             c_wr;

    assign c_wr = bus.Load && !(ZERO_R0 && bus.Caddr == '0);

    always_comb begin
        a_val = mem[bus.Aaddr];
        b_val = mem[bus.Baddr];
        if (c_wr && bus.Caddr == bus.Aaddr) a_val = bus.C;
        if (c_wr && bus.Caddr == bus.Baddr) b_val = bus.C;
        if (ZERO_R0 && bus.Aaddr == '0) a_val = '0;
        if (ZERO_R0 && bus.Baddr == '0) b_val = '0;
    end

    // Reserve is applied last so a new producer wins over flush and writeback.
    always_comb begin
        pend_n = bus.Flush ? '0 : pend;
        if (bus.Load) pend_n[bus.Caddr] = 1'b0;
        if (bus.Rsv) pend_n[bus.Rsvaddr] = 1'b1;
        if (ZERO_R0) pend_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend <= '0;
        end else begin
            if (c_wr) mem[bus.Caddr] <= bus.C;
            pend <= pend_n;
        end
    end

    assign bus.Abusy = pend[bus.Aaddr] &
                       ~(bus.Load & (bus.Caddr == bus.Aaddr));
    assign bus.Bbusy = pend[bus.Baddr] &
                       ~(bus.Load & (bus.Caddr == bus.Baddr));

    generate
        if (READ_REG) begin : g_rreg
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or negedge Clear_n) begin
                if (!Clear_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_val;
                    b_q <= b_val;
                end
            end

            assign bus.A = a_q;
            assign bus.B = b_q;
        end else begin : g_comb
            // Outputs are held at zero while reset is asserted.
            assign bus.A = Clear_n ? a_val : '0;
            assign bus.B = Clear_n ? b_val : '0;
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: combinational and registered-read instances share
// one stimulus stream and are compared against a behavioural model.
module tb_reg_file_sb;
    logic clk;
    logic Clear_n;
    int   checks;
    int   passed;

    reg_file_sb_if #(.WIDTH(16), .AW(4)) i0 ();
    reg_file_sb_if #(.WIDTH(16), .AW(4)) i1 ();

    assign i1.Aaddr   = i0.Aaddr;
    assign i1.Baddr   = i0.Baddr;
    assign i1.Caddr   = i0.Caddr;
    assign i1.Rsvaddr = i0.Rsvaddr;
    assign i1.C       = i0.C;
    assign i1.Load    = i0.Load;
    assign i1.Rsv     = i0.Rsv;
    assign i1.Flush   = i0.Flush;

    reg_file_sb #(.WIDTH(16), .DEPTH(16), .AW(4),
                  .ZERO_R0(1'b1), .READ_REG(1'b0)) dut0 (
        .clk(clk), .Clear_n(Clear_n), .bus(i0.slave));

    reg_file_sb #(.WIDTH(16), .DEPTH(16), .AW(4),
                  .ZERO_R0(1'b1), .READ_REG(1'b1)) dut1 (
        .clk(clk), .Clear_n(Clear_n), .bus(i1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model
    logic [15:0] mem_m [16];
    bit          pend_m [16];
    logic [15:0] aq_m;
    logic [15:0] bq_m;

    function automatic logic [15:0] rd_m(input int a);
        if (a == 0) return 16'h0;
        if (i0.Load && int'(i0.Caddr) == a) return i0.C;
        return mem_m[a];
    endfunction

    function automatic bit busy_m(input int a);
        return pend_m[a] && !(i0.Load && int'(i0.Caddr) == a);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            mem_m[r]  = 16'h0;
            pend_m[r] = 1'b0;
        end
        aq_m = 16'h0;
        bq_m = 16'h0;
    endtask

    task automatic tick();
        logic [15:0] na;
        logic [15:0] nb;
        na = rd_m(int'(i0.Aaddr));
        nb = rd_m(int'(i0.Baddr));
        @(posedge clk);
        if (!Clear_n) begin
            model_reset();
        end else begin
            for (int r = 0; r < 16; r++) begin
                bit p;
                bit rsv_here;
                bit ld_here;
                rsv_here = i0.Rsv && int'(i0.Rsvaddr) == r;
                ld_here  = i0.Load && int'(i0.Caddr) == r;
                p = i0.Flush ? 1'b0 : pend_m[r];
                if (ld_here && !rsv_here) p = 1'b0;
                if (rsv_here) p = 1'b1;
                if (r == 0) p = 1'b0;
                pend_m[r] = p;
                if (ld_here && r != 0) mem_m[r] = i0.C;
            end
            aq_m = na;
            bq_m = nb;
        end
        #1;
    endtask

    task automatic idle();
        i0.Load  = 1'b0;
        i0.Rsv   = 1'b0;
        i0.Flush = 1'b0;
    endtask

    task automatic test_reset();
        Clear_n  = 1'b0;
        idle();
        i0.Load  = 1'b1;
        i0.C     = 16'hFFFF;
        i0.Caddr = 4'd1;
        i0.Aaddr = 4'd1;
        i0.Baddr = 4'd1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (i0.A !== 16'h0 || i0.B !== 16'h0) begin
            $display("FAIL reset_ab comb A=%h B=%h want 0", i0.A, i0.B);
        end else passed++;
        checks++;
        if (i1.A !== 16'h0 || i1.B !== 16'h0) begin
            $display("FAIL reset_ab reg A=%h B=%h want 0", i1.A, i1.B);
        end else passed++;
        checks++;
        if (i0.Abusy !== 1'b0 || i0.Bbusy !== 1'b0) begin
            $display("FAIL reset_busy Abusy=%b Bbusy=%b want 0",
                     i0.Abusy, i0.Bbusy);
        end else passed++;
        i0.Load = 1'b0;
        #2 Clear_n = 1'b1;
        #1;
        checks++;
        if (i0.A !== 16'h0) begin
            $display("FAIL reset_r1 A=%h want 0", i0.A);
        end else passed++;
        tick();
    endtask

    task automatic test_write_read();
        i0.Load  = 1'b1;
        i0.Caddr = 4'd1;
        i0.C     = 16'h0001;
        tick();
        idle();
        i0.Aaddr = 4'd1;
        i0.Baddr = 4'd2;
        #1;
        checks++;
        if (i0.A !== 16'h0001) begin
            $display("FAIL wr_rd_a A=%h want 0001", i0.A);
        end else passed++;
        checks++;
        if (i0.B !== 16'h0000) begin
            $display("FAIL wr_rd_b B=%h want 0000", i0.B);
        end else passed++;
        tick();
    endtask

    task automatic test_bypass_zero();
        i0.Load  = 1'b1;
        i0.Caddr = 4'd5;
        i0.C     = 16'hBEEF;
        i0.Aaddr = 4'd5;
        #1;
        checks++;
        if (i0.A !== 16'hBEEF) begin
            $display("FAIL bypass A=%h want beef", i0.A);
        end else passed++;
        tick();
        i0.Caddr = 4'd0;
        i0.C     = 16'h1234;
        i0.Aaddr = 4'd0;
        #1;
        checks++;
        if (i0.A !== 16'h0) begin
            $display("FAIL zero_bypass A=%h want 0", i0.A);
        end else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (i0.A !== 16'h0) begin
            $display("FAIL zero_write A=%h want 0", i0.A);
        end else passed++;
    endtask

    task automatic test_scoreboard();
        i0.Rsv     = 1'b1;
        i0.Rsvaddr = 4'd3;
        tick();
        idle();
        i0.Aaddr = 4'd3;
        #1;
        checks++;
        if (i0.Abusy !== 1'b1) begin
            $display("FAIL sb_reserve Abusy=%b want 1", i0.Abusy);
        end else passed++;
        i0.Load  = 1'b1;
        i0.Caddr = 4'd3;
        i0.C     = 16'h0333;
        #1;
        checks++;
        if (i0.Abusy !== 1'b0) begin
            $display("FAIL sb_wb_comb Abusy=%b want 0", i0.Abusy);
        end else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (i0.Abusy !== 1'b0) begin
            $display("FAIL sb_wb_clear Abusy=%b want 0", i0.Abusy);
        end else passed++;
    endtask

    task automatic test_simultaneous();
        logic [15:0] v;
        v = 16'($urandom);
        i0.Rsv     = 1'b1;
        i0.Rsvaddr = 4'd4;
        i0.Load    = 1'b1;
        i0.Caddr   = 4'd4;
        i0.C       = v;
        tick();
        idle();
        i0.Aaddr = 4'd4;
        #1;
        checks++;
        if (i0.Abusy !== 1'b1 || i0.A !== v) begin
            $display("FAIL rsv_load Abusy=%b A=%h want 1 %h",
                     i0.Abusy, i0.A, v);
        end else passed++;
        i0.Rsv = 1'b1;
        for (int r = 8; r < 12; r++) begin
            i0.Rsvaddr = 4'(r);
            tick();
        end
        i0.Flush   = 1'b1;
        i0.Rsvaddr = 4'd6;
        tick();
        idle();
        for (int r = 0; r < 16; r++) begin
            i0.Aaddr = 4'(r);
            #1;
            checks++;
            if (i0.Abusy !== (r == 6)) begin
                $display("FAIL flush_rsv addr=%0d Abusy=%b want %b",
                         r, i0.Abusy, (r == 6));
            end else passed++;
        end
        tick();
    endtask

    task automatic test_registered();
        idle();
        i0.Aaddr = 4'd7;
        tick();
        i0.Load  = 1'b1;
        i0.Caddr = 4'd7;
        i0.C     = 16'h00A5;
        #1;
        checks++;
        if (i1.A !== 16'h0000) begin
            $display("FAIL rreg_early A=%h want 0000", i1.A);
        end else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (i1.A !== 16'h00A5) begin
            $display("FAIL rreg_late A=%h want 00a5", i1.A);
        end else passed++;
        #1 Clear_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (i1.A !== 16'h0 || i0.A !== 16'h0) begin
            $display("FAIL async_clr regA=%h combA=%h want 0", i1.A, i0.A);
        end else passed++;
        #1 Clear_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            i0.Aaddr   = 4'($urandom);
            i0.Baddr   = 4'($urandom);
            i0.Caddr   = 4'($urandom);
            i0.Rsvaddr = 4'($urandom);
            i0.C       = 16'($urandom);
            i0.Load    = 1'($urandom);
            i0.Rsv     = 1'($urandom);
            i0.Flush   = ($urandom_range(0, 15) == 0);
            if ((n % 4) == 1) i0.Aaddr = i0.Caddr;
            if ((n % 4) == 2) i0.Baddr = i0.Rsvaddr;
            #1;
            checks++;
            if (i0.A !== rd_m(int'(i0.Aaddr)) ||
                i0.B !== rd_m(int'(i0.Baddr))) begin
                $display("FAIL rnd_comb n=%0d A=%h B=%h want %h %h", n,
                         i0.A, i0.B, rd_m(int'(i0.Aaddr)),
                         rd_m(int'(i0.Baddr)));
            end else passed++;
            checks++;
            if (i0.Abusy !== busy_m(int'(i0.Aaddr)) ||
                i0.Bbusy !== busy_m(int'(i0.Baddr))) begin
                $display("FAIL rnd_busy n=%0d Abusy=%b Bbusy=%b want %b %b",
                         n, i0.Abusy, i0.Bbusy, busy_m(int'(i0.Aaddr)),
                         busy_m(int'(i0.Baddr)));
            end else passed++;
            checks++;
            if (i1.A !== aq_m || i1.B !== bq_m) begin
                $display("FAIL rnd_rreg n=%0d A=%h B=%h want %h %h",
                         n, i1.A, i1.B, aq_m, bq_m);
            end else passed++;
            checks++;
            if (i1.Abusy !== i0.Abusy || i1.Abusy !== busy_m(int'(i0.Aaddr))) begin
                $display("FAIL rnd_rbusy n=%0d Abusy=%b want %b",
                         n, i1.Abusy, busy_m(int'(i0.Aaddr)));
            end else passed++;
            tick();
        end
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        Clear_n    = 1'b0;
        i0.Aaddr   = '0;
        i0.Baddr   = '0;
        i0.Caddr   = '0;
        i0.Rsvaddr = '0;
        i0.C       = '0;
        idle();
        #1;
        test_reset();
        test_write_read();
        test_bypass_zero();
        test_scoreboard();
        test_simultaneous();
        test_registered();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
